// File: rtl/pmu_quota_regulator_pkg.sv
// Shared types and helpers for the PMU quota regulator.
// Settle time covers the monitor's pipelined sum over its counters.
package pmu_quota_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_MONITOR   = 3'd2,
    ST_STALL_REQ = 3'd3,
    ST_STALLED   = 3'd4
  } quota_reg_state_t;

  function automatic int unsigned settle_cycles(
    input int unsigned n_counters
  );
    return n_counters + 1;
  endfunction

endpackage

// File: rtl/pmu_quota_regulator_if.sv
// Monitor and core-stall handshake signals of the quota regulator.
// master = regulator side, slave = monitor/core side.
interface pmu_quota_regulator_if;

  logic intr_quota_i;
  logic stall_ack_i;
  logic quota_rst_o;
  logic stall_req_o;

  modport master (
    input  intr_quota_i,
    input  stall_ack_i,
    output quota_rst_o,
    output stall_req_o
  );

  modport slave (
    output intr_quota_i,
    output stall_ack_i,
    input  quota_rst_o,
    input  stall_req_o
  );

endinterface

// File: rtl/pmu_window_timer.sv
// Regulation-window timer; flags the last cycle of each window.
// A period shrunk below the count wraps at full width, no early end.
module pmu_window_timer #(
  parameter int unsigned PERIOD_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    win_end_o
);

  logic [PERIOD_WIDTH-1:0] win_cnt;

  assign win_end_o = (period_i != '0) &&
    (win_cnt == period_i - PERIOD_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      win_cnt <= '0;
    end else if (clr_i || win_end_o) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pmu_quota_regulator.sv
// Per-core responder to the PMU quota-monitor interrupt:
// sticky interrupt, optional core stall, per-window budget replenish.
module pmu_quota_regulator
  import pmu_quota_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned N_COUNTERS   = 9,
  parameter int unsigned OVR_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic                    mode_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    intr_clr_i,
  pmu_quota_regulator_if.master   bus,
  output logic                    intr_o,
  output logic [OVR_WIDTH-1:0]    overrun_cnt_o,
  output logic [2:0]              state_o
);

  localparam int unsigned SETTLE_CYC = settle_cycles(N_COUNTERS);
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  quota_reg_state_t state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [OVR_WIDTH-1:0] ovr_q;
  logic pend_q, pend_d;
  logic seen_q, seen_d;
  logic req_q, req_d;
  logic rst_q, rst_want;
  logic intr_q, hit;
  logic tmr_end, win_end, tmr_clr, settle_done;

  assign tmr_clr = ~enable_i | (state_q == ST_DISABLED);
  assign win_end = tmr_end & (state_q != ST_DISABLED);
  assign settle_done = (settle_q == SETTLE_LAST);

  pmu_window_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (tmr_clr),
    .period_i  (period_i),
    .win_end_o (tmr_end)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pend_d   = pend_q;
    seen_d   = seen_q;
    req_d    = req_q;
    rst_want = 1'b0;
    hit      = 1'b0;
    unique case (state_q)
      ST_DISABLED: begin
        if (enable_i) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          rst_want = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (win_end) begin
          rst_want = 1'b1;
          settle_d = '0;
        end else if (settle_done) begin
          // ack still high: wait for the four-phase return to zero
          if (!bus.stall_ack_i) state_d = ST_MONITOR;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_MONITOR: begin
        hit = bus.intr_quota_i;
        if (win_end) begin
          rst_want = 1'b1;
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (bus.intr_quota_i && mode_i) begin
          state_d = ST_STALL_REQ;
          req_d   = 1'b1;
        end
      end
      ST_STALL_REQ: begin
        if (bus.stall_ack_i) begin
          if (pend_q || win_end) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            req_d    = 1'b0;
            pend_d   = 1'b0;
            rst_want = win_end;
          end else begin
            state_d = ST_STALLED;
          end
        end else if (win_end) begin
          pend_d   = 1'b1;
          rst_want = 1'b1;
        end
      end
      ST_STALLED: begin
        if (win_end) begin
          rst_want = 1'b1;
          req_d    = 1'b0;
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
    if (win_end) seen_d = 1'b0;
    else if (hit) seen_d = 1'b1;
    if (!enable_i) begin
      state_d  = ST_DISABLED;
      settle_d = '0;
      pend_d   = 1'b0;
      seen_d   = 1'b0;
      req_d    = 1'b0;
      rst_want = 1'b0;
      hit      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_DISABLED;
      settle_q <= '0;
      pend_q   <= 1'b0;
      seen_q   <= 1'b0;
      req_q    <= 1'b0;
      rst_q    <= 1'b0;
      intr_q   <= 1'b0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pend_q   <= pend_d;
      seen_q   <= seen_d;
      req_q    <= req_d;
      rst_q    <= rst_want & ~rst_q;
      intr_q   <= hit | (intr_q & ~intr_clr_i);
      if (hit && !seen_q && (ovr_q != '1)) begin
        ovr_q <= ovr_q + OVR_WIDTH'(1);
      end
    end
  end

  assign bus.quota_rst_o = rst_q;
  assign bus.stall_req_o = req_q;
  assign intr_o          = intr_q;
  assign overrun_cnt_o   = ovr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pmu_quota_regulator.sv
// Directed scenarios plus random traffic against a reference model.
// Model phases follow the listed state order: DIS,SETTLE,MON,SREQ,STALLED.
module tb_pmu_quota_regulator;

  localparam int OVR_MAX = 3;
  localparam int SETTLE_CYC = 10;
  localparam int P_DIS = 0, P_SET = 1, P_MON = 2;
  localparam int P_SREQ = 3, P_STL = 4;

  logic clk;
  logic rstn;
  logic enable, mode, clr, quota, ack;
  logic [31:0] period;
  logic intr;
  logic [1:0] ovr;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  int m_ph, m_set, m_ovr;
  bit m_pend, m_seen, m_intr, m_req, m_rst;
  logic [31:0] m_wc;

  pmu_quota_regulator_if bus();

  assign bus.intr_quota_i = quota;
  assign bus.stall_ack_i  = ack;

  pmu_quota_regulator #(
    .PERIOD_WIDTH (32),
    .N_COUNTERS   (9),
    .OVR_WIDTH    (2)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .enable_i      (enable),
    .mode_i        (mode),
    .period_i      (period),
    .intr_clr_i    (clr),
    .bus           (bus),
    .intr_o        (intr),
    .overrun_cnt_o (ovr),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ph = P_DIS; m_set = 0; m_ovr = 0; m_wc = '0;
    m_pend = 0; m_seen = 0; m_intr = 0;
    m_req = 0; m_rst = 0;
  endtask

  task automatic do_reset();
    enable = 0; mode = 0; period = '0;
    clr = 0; quota = 0; ack = 0;
    rstn = 1'b0;
    #1;
    model_clear();
    chk("rst_intr", {31'b0, intr}, 0);
    chk("rst_req", {31'b0, bus.stall_req_o}, 0);
    chk("rst_qrst", {31'b0, bus.quota_rst_o}, 0);
    chk("rst_ovr", {30'b0, ovr}, 0);
    chk("rst_state", {29'b0, state}, P_DIS);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock: predict from current inputs, then compare after the edge
  task automatic tick();
    bit we, want, hit, cnt, npend, nseen, nreq;
    int nph, nset;
    logic [31:0] nwc;
    we = (m_ph != P_DIS) && (period != 0) &&
         (m_wc == period - 32'd1);
    nph = m_ph; nset = m_set; npend = m_pend;
    nseen = m_seen; nreq = m_req;
    want = 0; hit = 0;
    if (enable) begin
      case (m_ph)
        P_DIS: begin nph = P_SET; nset = 0; want = 1; end
        P_SET: begin
          if (we) begin want = 1; nset = 0; end
          else if (m_set >= SETTLE_CYC - 1) begin
            if (!ack) nph = P_MON;
          end else nset = m_set + 1;
        end
        P_MON: begin
          hit = quota;
          if (we) begin want = 1; nph = P_SET; nset = 0; end
          else if (quota && mode) begin nph = P_SREQ; nreq = 1; end
        end
        P_SREQ: begin
          if (ack) begin
            if (m_pend || we) begin
              nph = P_SET; nset = 0; nreq = 0;
              npend = 0; want = we;
            end else nph = P_STL;
          end else if (we) begin npend = 1; want = 1; end
        end
        default: begin
          if (we) begin want = 1; nreq = 0; nph = P_SET; nset = 0; end
        end
      endcase
      nseen = we ? 1'b0 : (m_seen | hit);
    end else begin
      nph = P_DIS; nset = 0; npend = 0; nseen = 0; nreq = 0;
    end
    cnt = hit && !m_seen;
    if (!enable || m_ph == P_DIS || we) nwc = '0;
    else nwc = m_wc + 32'd1;
    @(posedge clk);
    #1;
    m_intr = hit || (m_intr && !clr);
    if (cnt && m_ovr < OVR_MAX) m_ovr++;
    m_rst = want && !m_rst;
    m_ph = nph; m_set = nset; m_pend = npend;
    m_seen = nseen; m_req = nreq; m_wc = nwc;
    chk("intr", {31'b0, intr}, {31'b0, m_intr});
    chk("stall_req", {31'b0, bus.stall_req_o}, {31'b0, m_req});
    chk("quota_rst", {31'b0, bus.quota_rst_o}, {31'b0, m_rst});
    chk("overrun", {30'b0, ovr}, m_ovr);
    chk("state", {29'b0, state}, m_ph);
  endtask

  logic [31:0] plist [6] = '{0, 1, 3, 12, 25, 60};

  initial begin
    // 1: interrupt only
    do_reset();
    period = 100; mode = 0; enable = 1;
    tick();
    chk("t1_qrst0", {31'b0, bus.quota_rst_o}, 1);
    for (int t = 0; t < 100; t++) begin
      quota = (t == 30);
      tick();
      if (t + 1 == 31) begin
        chk("t1_intr31", {31'b0, intr}, 1);
        chk("t1_noreq", {31'b0, bus.stall_req_o}, 0);
      end
      if (t + 1 == 100) begin
        chk("t1_qrst100", {31'b0, bus.quota_rst_o}, 1);
        chk("t1_st100", {29'b0, state}, P_SET);
      end
    end
    chk("t1_ovr", {30'b0, ovr}, 1);

    // 2: interrupt + stall, ack held into next settle
    do_reset();
    period = 100; mode = 1; enable = 1;
    tick();
    for (int t = 0; t < 115; t++) begin
      quota = (t == 30);
      ack = (t >= 34 && t < 114);
      tick();
      if (t + 1 == 31) chk("t2_req31", {31'b0, bus.stall_req_o}, 1);
      if (t + 1 == 35) chk("t2_stalled", {29'b0, state}, P_STL);
      if (t + 1 == 99) chk("t2_req99", {31'b0, bus.stall_req_o}, 1);
      if (t + 1 == 100) begin
        chk("t2_req100", {31'b0, bus.stall_req_o}, 0);
        chk("t2_qrst100", {31'b0, bus.quota_rst_o}, 1);
      end
      if (t + 1 == 112) chk("t2_ext", {29'b0, state}, P_SET);
      if (t + 1 == 115) chk("t2_mon", {29'b0, state}, P_MON);
    end
    ack = 0;

    // 3: violation during settle is ignored
    do_reset();
    period = 100; mode = 0; enable = 1;
    tick();
    for (int t = 0; t < 12; t++) begin
      quota = (t < 10);
      tick();
    end
    chk("t3_intr", {31'b0, intr}, 0);
    chk("t3_ovr", {30'b0, ovr}, 0);
    chk("t3_mon", {29'b0, state}, P_MON);

    // 4: window ends while waiting for ack
    do_reset();
    period = 50; mode = 1; enable = 1;
    tick();
    for (int t = 0; t < 62; t++) begin
      quota = (t == 30);
      ack = (t >= 60);
      tick();
      if (t + 1 == 50) begin
        chk("t4_qrst50", {31'b0, bus.quota_rst_o}, 1);
        chk("t4_req50", {31'b0, bus.stall_req_o}, 1);
      end
      if (t + 1 == 61) begin
        chk("t4_req61", {31'b0, bus.stall_req_o}, 0);
        chk("t4_st61", {29'b0, state}, P_SET);
      end
    end
    ack = 0;

    // 5: clear vs set, overrun saturation
    do_reset();
    period = 20; mode = 0; enable = 1;
    tick();
    for (int t = 0; t < 100; t++) begin
      quota = (t % 20 == 12);
      clr = (t % 20 == 12) || (t % 20 == 15);
      tick();
      if ((t + 1) % 20 == 13) chk("t5_setwins", {31'b0, intr}, 1);
      if ((t + 1) % 20 == 16) chk("t5_clr", {31'b0, intr}, 0);
    end
    clr = 0; quota = 0;
    chk("t5_sat", {30'b0, ovr}, OVR_MAX);

    // 6: disable while stalled, then async reset
    do_reset();
    period = 100; mode = 1; enable = 1;
    tick();
    for (int t = 0; t < 40; t++) begin
      quota = (t == 30);
      ack = (t >= 34);
      tick();
    end
    chk("t6_stalled", {29'b0, state}, P_STL);
    enable = 0; quota = 0;
    tick();
    chk("t6_abort", {31'b0, bus.stall_req_o}, 0);
    chk("t6_dis", {29'b0, state}, P_DIS);
    chk("t6_keep", {31'b0, intr}, 1);
    ack = 0; enable = 1;
    for (int t = 0; t < 20; t++) tick();
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    chk("t6_aintr", {31'b0, intr}, 0);
    chk("t6_aovr", {30'b0, ovr}, 0);
    chk("t6_astate", {29'b0, state}, P_DIS);
    chk("t6_aqrst", {31'b0, bus.quota_rst_o}, 0);

    // random traffic
    do_reset();
    period = 25; enable = 1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 63) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 127) == 0) period = plist[$urandom_range(0, 5)];
      quota = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
